// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, data-memory wait freeze and taken-branch squash for the 5-stage pipe.
// Optional saturating stall-cycle counter is built only when HAZARD_STALL_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned RA_W      = 5,
  parameter int unsigned LU_CYCLES = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_ex_memread_i,
  input  logic [RA_W-1:0]  id_ex_rt_i,
  input  logic [RA_W-1:0]  if_id_rs_i,
  input  logic [RA_W-1:0]  if_id_rt_i,
  input  logic             if_id_uses_rt_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             pipe_freeze_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  typedef enum logic [1:0] {StRun, StLu, StMem} state_e;

  localparam logic [2:0] LuLoad = 3'(LU_CYCLES - 1);

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;
  logic [2:0] cnt_q, cnt_d;
  logic       haz, miss, stall, freeze, pc_adv;

  assign haz = id_ex_memread_i & (id_ex_rt_i != '0) &
               ((id_ex_rt_i == if_id_rs_i) | (if_id_uses_rt_i & (id_ex_rt_i == if_id_rt_i)));
  assign miss = dmem_req_i & ~dmem_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StRun;
      ret_q   <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    freeze  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (miss) begin
          freeze  = 1'b1;
          state_d = StMem;
          ret_d   = StRun;
        end else if (haz) begin
          stall = 1'b1;
          if (LU_CYCLES > 1) begin
            state_d = StLu;
            cnt_d   = LuLoad;
          end
        end
      end
      StLu: begin
        stall = 1'b1;
        // A miss here freezes without consuming a bubble; cnt resumes after MEM.
        if (miss) begin
          freeze  = 1'b1;
          state_d = StMem;
          ret_d   = StLu;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = StRun;
        end
      end
      StMem: begin
        freeze = 1'b1;
        if (dmem_ready_i) state_d = ret_q;
      end
      default: state_d = StRun;
    endcase
  end

  // Reset forces every enable low, including the normally-high advance enables.
  assign pc_adv         = rst_i & ~stall & ~freeze;
  assign pc_write_o     = pc_adv;
  assign if_id_write_o  = pc_adv;
  assign pipe_freeze_o  = rst_i & freeze;
  assign id_ex_bubble_o = rst_i & stall & ~freeze;
  assign if_id_flush_o  = branch_taken_i & pc_adv;

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (!pc_adv && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cycles_o = stall_cnt_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: one LU_CYCLES=3 instance and one LU_CYCLES=1 instance
// with a narrow counter, both driven by the same per-cycle stimulus.
module tb_hazard_ctrl;

  localparam int R = 0;  // run
  localparam int S = 1;  // stall
  localparam int F = 2;  // freeze
  localparam int Z = 3;  // in reset

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       memread = 1'b0, uses_rt = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;
  logic [4:0] ld_rt = '0, rs = '0, rt = '0;

  logic       a_pcw, a_ifw, a_fl, a_bub, a_frz;
  logic [7:0] a_sc;
  logic       b_pcw, b_ifw, b_fl, b_bub, b_frz;
  logic [2:0] b_sc;

  typedef struct {
    int ka;
    int kb;
    bit fa;
    bit fb;
    int ca;
    int cb;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc_n = 0;
  int   model_a = 0;
  int   model_b = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.RA_W(5), .LU_CYCLES(3), .CNT_W(8)) u_dut_a (
    .clk_i(clk), .rst_i(rst_i), .id_ex_memread_i(memread), .id_ex_rt_i(ld_rt),
    .if_id_rs_i(rs), .if_id_rt_i(rt), .if_id_uses_rt_i(uses_rt), .branch_taken_i(br),
    .dmem_req_i(req), .dmem_ready_i(rdy), .pc_write_o(a_pcw), .if_id_write_o(a_ifw),
    .if_id_flush_o(a_fl), .id_ex_bubble_o(a_bub), .pipe_freeze_o(a_frz),
    .stall_cycles_o(a_sc)
  );

  hazard_ctrl #(.RA_W(5), .LU_CYCLES(1), .CNT_W(3)) u_dut_b (
    .clk_i(clk), .rst_i(rst_i), .id_ex_memread_i(memread), .id_ex_rt_i(ld_rt),
    .if_id_rs_i(rs), .if_id_rt_i(rt), .if_id_uses_rt_i(uses_rt), .branch_taken_i(br),
    .dmem_req_i(req), .dmem_ready_i(rdy), .pc_write_o(b_pcw), .if_id_write_o(b_ifw),
    .if_id_flush_o(b_fl), .id_ex_bubble_o(b_bub), .pipe_freeze_o(b_frz),
    .stall_cycles_o(b_sc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic cmp(input string who, input logic pcw, input logic ifw, input logic fl,
                     input logic bub, input logic frz, input logic [31:0] sc, input int k,
                     input bit f, input int c);
    string p;
    p = $sformatf("c%0d %s", cyc_n, who);
    check({p, " pc_write"}, 32'(pcw), 32'(k == R));
    check({p, " if_id_write"}, 32'(ifw), 32'(k == R));
    check({p, " bubble"}, 32'(bub), 32'(k == S));
    check({p, " freeze"}, 32'(frz), 32'(k == F));
    check({p, " flush"}, 32'(fl), 32'(f));
    check({p, " stall_cnt"}, sc, 32'(c));
  endtask

  // One clock cycle: drive inputs, queue the expected response, then sample and compare.
  task automatic cyc(input logic rn, input logic m, input logic [4:0] lr, input logic [4:0] s,
                     input logic [4:0] t, input logic u, input logic b, input logic q,
                     input logic r, input int ka, input int kb);
    exp_t e;
    @(negedge clk);
    rst_i = rn; memread = m; ld_rt = lr; rs = s; rt = t; uses_rt = u; br = b; req = q; rdy = r;
    e.ka = ka;
    e.kb = kb;
    e.fa = b && (ka == R);
    e.fb = b && (kb == R);
`ifdef HAZARD_STALL_CNT_EN
    e.ca = (ka == Z) ? 0 : model_a;
    e.cb = (kb == Z) ? 0 : model_b;
`else
    e.ca = 0;
    e.cb = 0;
`endif
    sb.push_back(e);
    #3;
    e = sb.pop_front();
    cmp("A", a_pcw, a_ifw, a_fl, a_bub, a_frz, 32'(a_sc), e.ka, e.fa, e.ca);
    cmp("B", b_pcw, b_ifw, b_fl, b_bub, b_frz, 32'(b_sc), e.kb, e.fb, e.cb);
    if (ka == Z) model_a = 0;
    else if (ka != R && model_a < 255) model_a++;
    if (kb == Z) model_b = 0;
    else if (kb != R && model_b < 7) model_b++;
    cyc_n++;
  endtask

  task automatic idle(input int ka, input int kb);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, ka, kb);
  endtask

  initial begin
    // reset state
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z);
    cyc(0, 1, 8, 8, 0, 1, 1, 1, 0, Z, Z);
    idle(R, R);
    // lone taken branch flushes
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, R, R);
    // load-use on rs
    cyc(1, 1, 8, 8, 0, 1, 0, 0, 0, S, S);
    idle(S, R); idle(S, R); idle(R, R);
    // register 0 never stalls
    cyc(1, 1, 0, 0, 0, 1, 0, 0, 0, R, R);
    // rt match ignored when rt is not read
    cyc(1, 1, 8, 3, 8, 0, 0, 0, 0, R, R);
    // rt match with branch: stall wins, no flush
    cyc(1, 1, 8, 3, 8, 1, 1, 0, 0, S, S);
    idle(S, R); idle(S, R); idle(R, R);
    // hazard then miss inside LU; remaining bubbles resume after the freeze
    cyc(1, 1, 8, 8, 0, 1, 0, 0, 0, S, S);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, F, F);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, F, F);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, F, F);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, F, F);
    idle(S, R); idle(S, R); idle(R, R);
    // miss with branch held taken
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, F, F);
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, F, F);
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 1, F, F);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, R, R);
    // same-cycle ready is a hit
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, R, R);
    // return cycle from MEM re-evaluates hazard
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, F, F);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, F, F);
    cyc(1, 1, 9, 2, 9, 1, 0, 0, 0, S, S);
    idle(S, R); idle(S, R); idle(R, R);
    // reset mid-LU aborts at once; first cycle after release is RUN
    cyc(1, 1, 8, 8, 0, 1, 0, 0, 0, S, S);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z);
    cyc(1, 1, 8, 8, 0, 1, 0, 0, 0, S, S);
    idle(S, R); idle(S, R); idle(R, R);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
